// File: rtl/ir_queue.sv
// Instruction queue between fetch and decode for an LC-3b core.
// Circular buffer of {word, pc} entries. The head entry is decoded into its
// instruction fields combinationally. Outputs read as zero while the queue is empty.
module ir_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_word,
  input  logic [15:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_pc,
  output logic [3:0]       opcode,
  output logic [2:0]       dest,
  output logic [2:0]       src1,
  output logic [2:0]       src2,
  output logic [5:0]       offset6,
  output logic [8:0]       offset9,
  output logic [10:0]      offset11,
  output logic [7:0]       trapvect8,
  output logic [4:0]       imm5,
  output logic [3:0]       imm4,
  output logic             imm5mux_sel,
  output logic             ir11,
  output logic             abit,
  output logic             dbit,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [31:0]      head;
  logic [15:0]      hw;

  // Handshake qualifiers; flush suppresses both transfers.
  always_comb begin
    in_ready  = (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Pointer and occupancy next-state; power-of-two depth wraps pointers naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is written only by an accepted push; contents survive pop and flush.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {in_word, in_pc};
    end
  end

  // Head entry and its field decode, forced to zero when empty.
  always_comb begin
    head        = out_valid ? mem_q[rd_ptr_q] : '0;
    hw          = head[31:16];
    out_pc      = head[15:0];
    opcode      = hw[15:12];
    dest        = hw[11:9];
    src1        = hw[8:6];
    src2        = hw[2:0];
    offset6     = hw[5:0];
    offset9     = hw[8:0];
    offset11    = hw[10:0];
    trapvect8   = hw[7:0];
    imm5        = hw[4:0];
    imm4        = hw[3:0];
    imm5mux_sel = hw[5];
    ir11        = hw[11];
    abit        = hw[5];
    dbit        = hw[4];
    count       = count_q;
  end

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue (DEPTH=4) using a {word, pc} scoreboard queue.
module tb_ir_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [15:0]      in_word, in_pc, out_pc;
  logic [3:0]       opcode, imm4;
  logic [2:0]       dest, src1, src2;
  logic [5:0]       offset6;
  logic [8:0]       offset9;
  logic [10:0]      offset11;
  logic [7:0]       trapvect8;
  logic [4:0]       imm5;
  logic             imm5mux_sel, ir11, abit, dbit;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb[$];

  always #5 clk = ~clk;

  ir_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
    .offset6(offset6), .offset9(offset9), .offset11(offset11), .trapvect8(trapvect8),
    .imm5(imm5), .imm4(imm4), .imm5mux_sel(imm5mux_sel), .ir11(ir11),
    .abit(abit), .dbit(dbit), .count(count)
  );

  wire [75:0] dec_obs = {opcode, dest, src1, src2, offset6, offset9, offset11, trapvect8,
                         imm5, imm4, imm5mux_sel, ir11, abit, dbit, out_pc};

  // Expected head outputs for an entry {word, pc}.
  function automatic logic [75:0] exp_dec(input logic [31:0] e);
    logic [15:0] w;
    w = e[31:16];
    return {w[15:12], w[11:9], w[8:6], w[2:0], w[5:0], w[8:0], w[10:0], w[7:0],
            w[4:0], w[3:0], w[5], w[11], w[5], w[4], e[15:0]};
  endfunction

  // Update the scoreboard from the stimulus about to be clocked, then advance one cycle.
  task automatic tick();
    bit acc, pp;
    acc = in_valid && (sb.size() < DEPTH) && !flush && !reset;
    pp  = out_ready && (sb.size() > 0) && !flush && !reset;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back({in_word, in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; flush = 0; in_valid = 0; out_ready = 0; in_word = '0; in_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    checks++; if (count !== '0) begin failures++;
      $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (dec_obs !== '0) begin failures++;
      $display("FAIL reset_decode: got %h expected 0", dec_obs); end
  endtask

  task automatic test_basic();
    in_valid = 1; in_word = 16'h1283; in_pc = 16'h3000;
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL basic_no_bypass: got out_valid=%b expected 0", out_valid); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin failures++;
      $display("FAIL basic_valid_count: got %b/%0d expected 1/1", out_valid, count); end
    checks++;
    if (opcode !== 4'd1 || dest !== 3'd1 || src1 !== 3'd2 || src2 !== 3'd3 ||
        imm5mux_sel !== 1'b0 || out_pc !== 16'h3000) begin failures++;
      $display("FAIL basic_fields: got op=%h d=%h s1=%h s2=%h m=%b pc=%h expected 1/1/2/3/0/3000",
               opcode, dest, src1, src2, imm5mux_sel, out_pc); end
    checks++; if (dec_obs !== exp_dec(sb[0])) begin failures++;
      $display("FAIL basic_decode: got %h expected %h", dec_obs, exp_dec(sb[0])); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++;
      $display("FAIL basic_pop: got %0d/%b expected 0/0", count, out_valid); end
  endtask

  task automatic test_full();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_word = 16'h5000 + 16'(i * 16'h0111); in_pc = 16'h4000 + 16'(2 * i);
      if (i < 4) tick();
    end
    checks++; if (in_ready !== 1'b0 || count !== 3'd4) begin failures++;
      $display("FAIL full_stall: got in_ready=%b count=%0d expected 0/4", in_ready, count); end
    tick();
    tick();
    checks++; if (count !== 3'd4 || dec_obs !== exp_dec(sb[0])) begin failures++;
      $display("FAIL full_hold: got count=%0d head=%h expected 4/%h", count, dec_obs,
               exp_dec(sb[0])); end
    out_ready = 1;
    tick();
    out_ready = 0;
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin failures++;
      $display("FAIL full_after_pop: got count=%0d in_ready=%b expected 3/1", count, in_ready); end
    tick();
    in_valid = 0;
    checks++; if (count !== 3'd4 || sb[3][31:16] !== 16'h5444) begin failures++;
      $display("FAIL full_fifth_accepted: got count=%0d expected 4", count); end
    out_ready = 1;
    for (int n = 0; n < 10 && sb.size() > 0; n++) begin
      checks++; if (dec_obs !== exp_dec(sb[0])) begin failures++;
        $display("FAIL full_order: got %h expected %h", dec_obs, exp_dec(sb[0])); end
      tick();
    end
    out_ready = 0;
    checks++; if (count !== 3'd0) begin failures++;
      $display("FAIL full_drain: got %0d expected 0", count); end
  endtask

  task automatic test_push_pop();
    in_valid = 1; in_word = 16'h1042; in_pc = 16'h3100; tick();
    in_word = 16'h6285; in_pc = 16'h3102; tick();
    in_word = 16'hF025; in_pc = 16'h3104; out_ready = 1;
    checks++; if (dec_obs !== exp_dec(sb[0])) begin failures++;
      $display("FAIL pp_head: got %h expected %h", dec_obs, exp_dec(sb[0])); end
    tick();
    in_valid = 0; out_ready = 0;
    checks++; if (count !== 3'd2) begin failures++;
      $display("FAIL pp_count: got %0d expected 2", count); end
    out_ready = 1;
    for (int n = 0; n < 6 && sb.size() > 0; n++) begin
      checks++; if (dec_obs !== exp_dec(sb[0])) begin failures++;
        $display("FAIL pp_order: got %h expected %h", dec_obs, exp_dec(sb[0])); end
      if (sb[0][31:16] == 16'hF025) begin
        checks++; if (opcode !== 4'hF || trapvect8 !== 8'h25) begin failures++;
          $display("FAIL pp_trap: got op=%h tv=%h expected f/25", opcode, trapvect8); end
      end
      tick();
    end
    out_ready = 0;
  endtask

  task automatic test_flush();
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_word = 16'h2000 + 16'(i); in_pc = 16'h3200 + 16'(2 * i); tick();
    end
    in_valid = 0;
    checks++; if (count !== 3'd3) begin failures++;
      $display("FAIL flush_fill: got %0d expected 3", count); end
    flush = 1; in_valid = 1; in_word = 16'hDEAD; in_pc = 16'hBEEF; out_ready = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || dec_obs !== '0) begin failures++;
      $display("FAIL flush_clear: got count=%0d valid=%b dec=%h expected 0/0/0",
               count, out_valid, dec_obs); end
    in_valid = 1; in_word = 16'h3A5C; in_pc = 16'h3300; tick();
    in_valid = 0;
    checks++; if (count !== 3'd1 || dec_obs !== exp_dec(32'h3A5C_3300)) begin failures++;
      $display("FAIL flush_refill: got count=%0d dec=%h expected 1/%h", count, dec_obs,
               exp_dec(32'h3A5C_3300)); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_stream();
    logic [15:0] words[10];
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < 10; i++) words[i] = 16'(i * 16'h1357 + 16'h0A0B);
    while ((idx < 10 || sb.size() > 0) && cyc < 300) begin
      in_valid  = (idx < 10);
      in_word   = (idx < 10) ? words[idx] : 16'h0;
      in_pc     = 16'h3400 + 16'(2 * idx);
      out_ready = 1'($urandom_range(0, 1));
      checks++; if (count !== CNT_W'(sb.size()) || count > 3'd4) begin failures++;
        $display("FAIL stream_count: got %0d expected %0d", count, sb.size()); end
      if (out_ready && sb.size() > 0) begin
        checks++; if (dec_obs !== exp_dec(sb[0])) begin failures++;
          $display("FAIL stream_order: got %h expected %h", dec_obs, exp_dec(sb[0])); end
      end
      if (in_valid && sb.size() < DEPTH) idx++;
      tick();
      cyc++;
    end
    in_valid = 0; out_ready = 0;
    checks++; if (cyc >= 300) begin failures++;
      $display("FAIL stream_timeout: got %0d cycles expected under 300", cyc); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_word = 16'h1111; in_pc = 16'h3500; tick();
    in_word = 16'h2222; in_pc = 16'h3502; tick();
    checks++; if (count !== 3'd2) begin failures++;
      $display("FAIL rmid_fill: got %0d expected 2", count); end
    reset = 1; in_word = 16'h3333; in_pc = 16'h3504;
    tick();
    reset = 0; in_valid = 0;
    checks++; if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++;
      $display("FAIL rmid_state: got count=%0d in_ready=%b valid=%b expected 0/1/0",
               count, in_ready, out_valid); end
    in_valid = 1; in_word = 16'hE1F0; in_pc = 16'h3600; tick();
    in_valid = 0;
    checks++; if (count !== 3'd1 || dec_obs !== exp_dec(32'hE1F0_3600)) begin failures++;
      $display("FAIL rmid_restart: got count=%0d dec=%h expected 1/%h", count, dec_obs,
               exp_dec(32'hE1F0_3600)); end
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_full();
    test_push_pop();
    test_flush();
    test_stream();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries held; SHALL be a power of two and at least 2.
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy count.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all queued entries (branch/trap redirect).
REQ-006 in_valid  input  1  in_word/in_pc present for push.
REQ-007 in_ready  output  1  queue can accept a push this cycle.
REQ-008 in_word  input  16  fetched LC-3b instruction word.
REQ-009 in_pc  input  16  address of in_word.
REQ-010 out_valid  output  1  head entry valid; decode outputs meaningful.
REQ-011 out_ready  input  1  consumer takes head entry this cycle.
REQ-012 out_pc  output  16  PC of head entry.
REQ-013 opcode  output  4  head word [15:12].
REQ-014 dest, src1, src2  output  3 each  head word [11:9], [8:6], [2:0].
REQ-015 offset6, offset9, offset11, trapvect8  output  6/9/11/8  head word [5:0], [8:0], [10:0], [7:0].
REQ-016 imm5, imm4  output  5/4  head word [4:0], [3:0].
REQ-017 imm5mux_sel, ir11, abit, dbit  output  1 each  head word [5], [11], [5], [4].
REQ-018 count  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-019 Storage: DEPTH x 32-bit circular buffer (word + pc), write pointer and read pointer each log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-020 in_ready SHALL equal (count < DEPTH); no same-cycle pass-through when full.
REQ-021 Push occurs when in_valid && in_ready && !flush: entry written at write pointer, write pointer +1.
REQ-022 Pop occurs when out_valid && out_ready && !flush: read pointer +1.
REQ-023 out_valid SHALL equal (count != 0).
REQ-024 Latency: a pushed word SHALL appear at the head outputs in the cycle after the push edge when queue was empty; no bypass of an empty queue.
REQ-025 Simultaneous push and pop: both pointers advance, count unchanged; legal at any count 1..DEPTH-1.
REQ-026 count: +1 on push-only, -1 on pop-only, unchanged otherwise; never exceeds DEPTH, never underflows.
REQ-027 All decode outputs and out_pc SHALL be combinational slices of the head entry when out_valid=1, and all-zero when out_valid=0.
REQ-028 flush: at the edge, count, read and write pointers SHALL go to 0; any push or pop asserted that cycle SHALL be ignored; storage contents need not be cleared.
REQ-029 Storage array SHALL only be written on a push; pop and flush SHALL not modify stored data.
REQ-030 in_valid while full SHALL simply stall (in_ready=0); the entry is not lost provided the producer holds it.

Reset
REQ-031 reset SHALL take priority over flush, push and pop.
REQ-032 After reset edge: count=0, pointers=0, out_valid=0, in_ready=1, all decode outputs and out_pc=0.
REQ-033 reset asserted mid-stream SHALL discard all entries in one cycle; the push attempted that cycle SHALL be dropped.

Verification
REQ-034 Reset, then push 0x1283 pc 0x3000 -> next cycle out_valid=1, opcode=1, dest=1, src1=2, src2=3, imm5mux_sel=0, out_pc=0x3000, count=1.
REQ-035 DEPTH=4: push 5 words with out_ready=0 -> in_ready=0 after 4th, count=4, 5th held; pop once -> 5th accepted next cycle, order preserved.
REQ-036 Push 0xF025 with simultaneous pop of prior head at count=2 -> count stays 2; when at head, opcode=0xF, trapvect8=0x25.
REQ-037 Fill to count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, decode outputs 0; pushed word not present.
REQ-038 Stream 10 words through DEPTH=4 with randomised out_ready -> pointers wrap, output sequence equals input sequence, count never >4.
REQ-039 Assert reset with count=2 and push active -> next cycle count=0, in_ready=1, out_valid=0.
